scroll_scheduler: RTL and testbench
===================================

Name: scroll_scheduler

Overview:
Arbitrates up to N_REQ message sources for the single 4-digit scrolling seven-segment display path. It grants one requester at a time round-robin, latches its 32-bit (8-nibble) message, and rotates it one nibble per scroll tick for PASSES full rotations. The top 16 bits drive the digit display module. The block also generates its own scroll tick from the system clock, so no separate slow clock is needed.

Parameters:
N_REQ, 4, number of requesters (2..8)
DIV, 33333333, system clocks per scroll tick (100 MHz -> ~3 Hz); must be >=2
PASSES, 1, full 8-nibble rotations shown per grant (>=1)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
req  in  N_REQ  per-source display request, level
msg_in  in  32*N_REQ  source i message at bits [32*i+31:32*i]
pause  in  1  freeze scrolling while high
dir  in  1  0 = rotate left (nibble [31:28] wraps to [3:0]), 1 = rotate right
grant  out  N_REQ  one-hot owner, all-zero when idle
busy  out  1  high in SHOW
done  out  1  one-cycle pulse when a grant completes
dataBus  out  16  shift register bits [31:16] to digit display

Behaviour:
- Reset (clr low, async): state=IDLE, shift reg=0, dataBus=0, grant=0, busy=0, done=0, prescaler=0, step=0, rr pointer=0.
- States: IDLE, SHOW, DONE.
- IDLE: if any req bit set, pick first set index searching ptr, ptr+1, ... wrapping modulo N_REQ. Same edge: shift reg<=msg of winner, grant<=onehot(winner), prescaler<=0, step<=0, -> SHOW. If no req, stay; shift reg and dataBus hold last value.
- SHOW: busy=1, grant held. Prescaler counts 0..DIV-1 when pause=0. Tick = (prescaler==DIV-1 && !pause). Tick wraps prescaler to 0.
- On tick: rotate shift reg by one nibble per dir, sampled on that cycle. Increment step. If step==8*PASSES-1 on the tick, -> DONE.
- pause=1 freezes prescaler, step and shift reg. Resuming continues from the frozen count.
- Winner dropping req, or msg_in changing, during SHOW has no effect, because the message is latched.
- After 8*PASSES ticks with constant dir, the shift reg equals the original message. Mixed dir values give no such guarantee.
- DONE: lasts one cycle. done=1, busy=0, grant<=0, ptr<=winner+1 mod N_REQ. Then -> IDLE. Shift reg holds.
- A requester still asserting req in IDLE re-competes. Round-robin guarantees other pending sources are served first.
- First dataBus change after grant: load edge (msg bits [31:16]). Then every DIV unpaused clocks.
- Reset mid-SHOW aborts immediately to reset values. No done pulse.
- Counter widths: prescaler ceil(log2(DIV)); step ceil(log2(8*PASSES)); no overflow by construction.

Test Plan:
(Bench uses DIV=4, N_REQ=4, PASSES=1.)
1. Reset, then req=4'b0001, msg0=32'h1234_5678, dir=0. Required: grant=0001 and dataBus=16'h1234 the edge after load. After 4 clocks dataBus=16'h2345, then 16'h3456. After 8 ticks: done pulse, grant=0, dataBus=16'h1234.
2. Same setup with dir=1. Required: dataBus sequence 16'h1234 -> 16'h8123 -> 16'h7812 -> ... -> 16'h1234. done fires after 32 clocks in SHOW.
3. req=4'b1111 held constantly, distinct msgs. Required: grants in order 0001, 0010, 0100, 1000, 0001. done pulse between each grant; no source granted twice in a row.
4. During SHOW, hold pause high for 10 clocks. Required: dataBus, prescaler and step frozen. Total SHOW length = 32+10 clocks.
5. During SHOW, drop req and change msg0. Required: scrolling continues with the latched message until done.
6. Pull clr low mid-SHOW at step 3. Required: grant=0, busy=0, dataBus=0 immediately (async), no done pulse. With req still high after release, the block re-grants from index 0.

Source files
------------

// File: rtl/scroll_scheduler.sv
// Round-robin owner of the scrolling seven-segment path: latches the winner's
// 32-bit message and rotates it one nibble per self-generated scroll tick.
module scroll_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DIV    = 33333333,
    parameter int PASSES = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  msg_in,
    input  logic                 pause,
    input  logic                 dir,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          dataBus
);

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = $clog2(DIV);
    localparam int STEPS = 8 * PASSES;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_shift;
    logic [N_REQ-1:0]  r_grant;
    logic [PW-1:0]     r_ptr, r_win;
    logic [CW-1:0]     r_presc;
    logic [SW-1:0]     r_step;

    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW:0]       w_idx;
    logic              w_tick;
    logic              w_last;
    logic [31:0]       w_rot;
    logic [PW-1:0]     w_ptr_nxt;

    // Search ptr, ptr+1, ... modulo N_REQ; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N_REQ))
                w_idx = w_idx - (PW+1)'(N_REQ);
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    assign w_tick    = (r_state == SHOW) && !pause && (r_presc == CW'(DIV-1));
    assign w_last    = (r_step == SW'(STEPS-1));
    assign w_rot     = dir ? {r_shift[3:0], r_shift[31:4]} : {r_shift[27:0], r_shift[31:28]};
    assign w_ptr_nxt = (r_win == PW'(N_REQ-1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = SHOW;
            SHOW:    if (w_tick && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_shift <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_presc <= '0;
            r_step  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_shift <= msg_in[32*int'(w_win) +: 32];
                    r_grant <= N_REQ'(1) << w_win;
                    r_win   <= w_win;
                    r_presc <= '0;
                    r_step  <= '0;
                end
                SHOW: if (!pause) begin
                    if (w_tick) begin
                        r_presc <= '0;
                        r_shift <= w_rot;
                        r_step  <= r_step + 1'b1;
                        if (w_last) r_grant <= '0;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                DONE: r_ptr <= w_ptr_nxt;
                default: ;
            endcase
        end
    end

    assign grant   = r_grant;
    assign busy    = (r_state == SHOW);
    assign done    = (r_state == DONE);
    assign dataBus = r_shift[31:16];

endmodule

// File: tb/tb_scroll_scheduler.sv
// Scoreboard bench for scroll_scheduler (DIV=4, N_REQ=4, PASSES=1): expected
// grants and dataBus snapshots are queued at stimulus time and popped at checks.
module tb_scroll_scheduler;

    localparam int N_REQ = 4;
    localparam int DIV   = 4;

    logic                clk = 1'b0;
    logic                clr;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] msg_in;
    logic                pause;
    logic                dir;
    logic [N_REQ-1:0]    grant;
    logic                busy;
    logic                done;
    logic [15:0]         dataBus;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]      exp_q[$];
    logic [N_REQ-1:0] gnt_q[$];

    scroll_scheduler #(.N_REQ(N_REQ), .DIV(DIV), .PASSES(1)) dut (
        .clk(clk), .clr(clr), .req(req), .msg_in(msg_in), .pause(pause), .dir(dir),
        .grant(grant), .busy(busy), .done(done), .dataBus(dataBus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Everything stays aligned to negedges; step(n) lets n rising edges pass.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] pop_d();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [N_REQ-1:0] pop_g();
        if (gnt_q.size() == 0) return 'x;
        return gnt_q.pop_front();
    endfunction

    task automatic push_msg(input logic [31:0] m, input logic d);
        logic [31:0] s;
        s = m;
        exp_q.push_back(s[31:16]);
        for (int t = 0; t < 8; t++) begin
            s = d ? {s[3:0], s[31:4]} : {s[27:0], s[31:28]};
            exp_q.push_back(s[31:16]);
        end
    endtask

    task automatic apply_reset();
        clr = 1'b0;
        step(2);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(dataBus), 0);
        clr = 1'b1;
        step(1);
    endtask

    // Called on the negedge just after the load edge; ends on the DONE cycle.
    task automatic run_show(input bit mutate);
        chk("load_grant", 32'(grant), 32'(pop_g()));
        chk("load_busy", 32'(busy), 1);
        chk("load_data", 32'(dataBus), 32'(pop_d()));
        if (mutate) begin
            req = '0;
            msg_in[31:0] = 32'hDEAD_BEEF;
        end
        for (int t = 1; t <= 8; t++) begin
            step(DIV);
            chk("tick_data", 32'(dataBus), 32'(pop_d()));
            if (t < 8) begin
                chk("show_busy", 32'(busy), 1);
                chk("show_done", 32'(done), 0);
            end else begin
                chk("end_done", 32'(done), 1);
                chk("end_grant", 32'(grant), 0);
                chk("end_busy", 32'(busy), 0);
            end
        end
    endtask

    initial begin
        clr = 1'b0; req = '0; msg_in = '0; pause = 1'b0; dir = 1'b0;
        step(1);
        apply_reset();

        // left rotation, single source
        msg_in[31:0] = 32'h1234_5678;
        push_msg(32'h1234_5678, 1'b0);
        gnt_q.push_back(4'b0001);
        req = 4'b0001;
        step(1);
        run_show(1'b0);
        req = '0;
        step(1);
        chk("idle_done", 32'(done), 0);
        chk("idle_hold", 32'(dataBus), 32'h1234);

        // right rotation
        dir = 1'b1;
        push_msg(32'h1234_5678, 1'b1);
        gnt_q.push_back(4'b0001);
        req = 4'b0001;
        step(1);
        run_show(1'b0);
        req = '0; dir = 1'b0;
        step(1);

        // round robin with all sources requesting
        apply_reset();
        msg_in = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        for (int i = 0; i < 5; i++) begin
            gnt_q.push_back(N_REQ'(1) << (i % N_REQ));
            push_msg(msg_in[32*(i % N_REQ) +: 32], 1'b0);
        end
        req = 4'b1111;
        step(1);
        for (int i = 0; i < 5; i++) begin
            run_show(1'b0);
            if (i < 4) begin
                step(1);
                chk("gap_grant", 32'(grant), 0);
                step(1);
            end
        end
        req = '0;
        step(1);

        // pause for 10 clocks mid-show
        msg_in[31:0] = 32'hCAFE_F00D;
        push_msg(32'hCAFE_F00D, 1'b0);
        gnt_q.push_back(4'b0001);
        req = 4'b0001;
        step(1);
        chk("p_grant", 32'(grant), 32'(pop_g()));
        chk("p_load", 32'(dataBus), 32'(pop_d()));
        req = '0;
        step(DIV);
        chk("p_tick1", 32'(dataBus), 32'(exp_q[0]));
        step(2);
        pause = 1'b1;
        step(10);
        chk("p_frozen", 32'(dataBus), 32'(exp_q[0]));
        chk("p_busy", 32'(busy), 1);
        pause = 1'b0;
        step(1);
        chk("p_resume", 32'(dataBus), 32'(pop_d()));
        step(1);
        chk("p_tick2", 32'(dataBus), 32'(pop_d()));
        for (int t = 3; t <= 8; t++) begin
            chk("p_busy_run", 32'(busy), 1);
            step(DIV);
            chk("p_tick", 32'(dataBus), 32'(pop_d()));
        end
        chk("p_done", 32'(done), 1);
        step(1);

        // drop request and change message while showing
        msg_in[31:0] = 32'h0F1E_2D3C;
        push_msg(32'h0F1E_2D3C, 1'b0);
        gnt_q.push_back(4'b0001);
        req = 4'b0001;
        step(1);
        run_show(1'b1);
        step(1);

        // reset at step 3 aborts; pointer restarts at 0
        msg_in[31:0] = 32'h9876_5432;
        req = 4'b0001;
        step(1);
        chk("r_grant", 32'(grant), 32'b0001);
        req = 4'b0011;
        step(3 * DIV + 1);
        chk("r_busy_pre", 32'(busy), 1);
        clr = 1'b0;
        #1;
        chk("r_grant0", 32'(grant), 0);
        chk("r_busy0", 32'(busy), 0);
        chk("r_data0", 32'(dataBus), 0);
        chk("r_done0", 32'(done), 0);
        step(1);
        chk("r_nodone", 32'(done), 0);
        clr = 1'b1;
        step(1);
        chk("r_regrant", 32'(grant), 32'b0001);
        chk("r_reload", 32'(dataBus), 32'h9876);
        req = '0;
        step(1);

        chk("q_empty", 32'(exp_q.size() + gnt_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
